// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - round-robin scheduler sharing one 6-digit display among three requesters
module seg_disp_sched #(
    parameter logic [15:0] CNT_MAX  = 16'd49_999,
    parameter logic [11:0] HOLD_MS  = 12'd2000,
    parameter logic [7:0]  BLANK_MS = 8'd100
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  req,
    input  logic [59:0] data_in,
    input  logic [17:0] point_in,
    input  logic [2:0]  sign_in,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic [2:0]  gnt
);

    localparam logic [19:0] DATA_MAX = 20'd999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [11:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        seg_en_q, seg_en_d;
    logic [19:0] data_q, data_d;
    logic [5:0]  point_q, point_d;
    logic        sign_q, sign_d;

    logic        tick, hold_done, blank_done;
    logic        win_req, others_req, restart, cnt_clr;
    logic [1:0]  rr_win;
    logic [19:0] sel_data;
    logic [5:0]  sel_point;
    logic        sel_sign;

    // Search starts just after the last granted requester; caller guarantees r != 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
        w = 2'd0;
        case (last)
            2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return w;
    endfunction

    // Hold and blank expire on the edge that delivers the final tick.
    assign tick       = (ms_cnt_q == CNT_MAX);
    assign hold_done  = tick && (tick_cnt_q == HOLD_MS - 12'd1);
    assign blank_done = tick && (tick_cnt_q == {4'd0, BLANK_MS} - 12'd1);
    assign win_req    = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign rr_win     = rr_pick(req, last_q);

    always_comb begin
        sel_data  = data_in[59:40];
        sel_point = point_in[17:12];
        sel_sign  = sign_in[2];
        case (last_q)
            2'd0: begin
                sel_data  = data_in[19:0];
                sel_point = point_in[5:0];
                sel_sign  = sign_in[0];
            end
            2'd1: begin
                sel_data  = data_in[39:20];
                sel_point = point_in[11:6];
                sel_sign  = sign_in[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        seg_en_d = seg_en_q;
        restart  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d    = 3'b000;
                seg_en_d = 1'b0;
                if (|req) begin
                    state_d  = SHOW;
                    last_d   = rr_win;
                    gnt_d    = 3'b001 << rr_win;
                    seg_en_d = 1'b1;
                end
            end
            SHOW: begin
                // Early deassert wins over a coincident hold expiry.
                if (!win_req || (hold_done && others_req)) begin
                    state_d  = BLANK;
                    gnt_d    = 3'b000;
                    seg_en_d = 1'b0;
                end else if (hold_done) begin
                    restart = 1'b1;
                end
            end
            BLANK: begin
                if (blank_done) begin
                    if (|req) begin
                        state_d  = SHOW;
                        last_d   = rr_win;
                        gnt_d    = 3'b001 << rr_win;
                        seg_en_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = 3'b000;
                seg_en_d = 1'b0;
            end
        endcase
    end

    assign cnt_clr = restart || (state_d != state_q) || (state_q == IDLE);

    always_comb begin
        ms_cnt_d   = ms_cnt_q + 16'd1;
        tick_cnt_d = tick_cnt_q;
        if (cnt_clr) begin
            ms_cnt_d   = 16'd0;
            tick_cnt_d = 12'd0;
        end else if (tick) begin
            ms_cnt_d   = 16'd0;
            tick_cnt_d = tick_cnt_q + 12'd1;
        end
    end

    always_comb begin
        data_d  = data_q;
        point_d = point_q;
        sign_d  = sign_q;
        if (state_q == SHOW) begin
            data_d  = (sel_data > DATA_MAX) ? DATA_MAX : sel_data;
            point_d = sel_point;
            sign_d  = sel_sign;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            ms_cnt_q   <= 16'd0;
            tick_cnt_q <= 12'd0;
            last_q     <= 2'd2;
            gnt_q      <= 3'b000;
            seg_en_q   <= 1'b0;
            data_q     <= 20'd0;
            point_q    <= 6'd0;
            sign_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_cnt_q   <= ms_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            seg_en_q   <= seg_en_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
        end
    end

    assign data   = data_q;
    assign point  = point_q;
    assign sign   = sign_q;
    assign seg_en = seg_en_q;
    assign gnt    = gnt_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb/tb_seg_disp_sched.sv - self-checking bench for seg_disp_sched
module tb_seg_disp_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [59:0] data_in = 60'd0;
    logic [17:0] point_in = 18'd0;
    logic [2:0]  sign_in = 3'b000;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [2:0]  gnt;

    int          n_tests = 0;
    int          n_fail = 0;
    int          inv_bad = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  exp_g;
    logic [2:0]  prev_gnt = 3'b000;

    always #5 sys_clk = ~sys_clk;

    seg_disp_sched #(
        .CNT_MAX (16'd9),
        .HOLD_MS (12'd3),
        .BLANK_MS(8'd2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req),
        .data_in  (data_in),
        .point_in (point_in),
        .sign_in  (sign_in),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en),
        .gnt      (gnt)
    );

    // Every new grant is matched against the next expected grant in order.
    always @(negedge sys_clk) begin
        if (sys_rst_n && gnt !== prev_gnt && gnt !== 3'b000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_grant: got %b, expected no new grant", gnt);
            end else begin
                exp_g = exp_q.pop_front();
                if (gnt !== exp_g) begin
                    n_fail++;
                    $display("FAIL sb_grant: got %b, expected %b", gnt, exp_g);
                end
            end
        end
        if (sys_rst_n) begin
            if (!$onehot0(gnt) || (seg_en !== 1'b1 && gnt !== 3'b000) ||
                (seg_en === 1'b1 && gnt === 3'b000))
                inv_bad++;
        end
        prev_gnt = gnt;
    end

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req       = 3'b000;
        data_in   = 60'd0;
        point_in  = 18'd0;
        sign_in   = 3'b000;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d grants pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int bad;
        sys_rst_n = 1'b0;
        req       = 3'b000;
        repeat (2) @(negedge sys_clk);
        n_tests++;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b, expected 000", gnt); end
        n_tests++;
        if (seg_en !== 1'b0) begin n_fail++; $display("FAIL reset_seg_en: got %b, expected 0", seg_en); end
        n_tests++;
        if (data !== 20'd0) begin n_fail++; $display("FAIL reset_data: got %0d, expected 0", data); end
        n_tests++;
        if (point !== 6'd0) begin n_fail++; $display("FAIL reset_point: got %b, expected 000000", point); end
        n_tests++;
        if (sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign: got %b, expected 0", sign); end
        sys_rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (gnt !== 3'b000 || seg_en !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_no_req_idle: got %0d busy cycles, expected 0", bad); end
    endtask

    task automatic test_single_hold();
        int bad;
        do_reset();
        @(negedge sys_clk);
        data_in[19:0] = 20'd123456;
        point_in[5:0] = 6'h15;
        sign_in       = 3'b001;
        req           = 3'b001;
        exp_q.push_back(3'b001);
        @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b1) begin n_fail++; $display("FAIL single_seg_en: got %b, expected 1", seg_en); end
        n_tests++;
        if (data !== 20'd0) begin n_fail++; $display("FAIL single_data_latency: got %0d, expected 0", data); end
        @(negedge sys_clk);
        n_tests++;
        if (data !== 20'd123456) begin n_fail++; $display("FAIL single_data: got %0d, expected 123456", data); end
        n_tests++;
        if (point !== 6'h15 || sign !== 1'b1) begin
            n_fail++; $display("FAIL single_point_sign: got %h/%b, expected 15/1", point, sign);
        end
        bad = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (seg_en !== 1'b1 || gnt !== 3'b001) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL single_hold_restart: got %0d gaps, expected 0", bad); end
        req = 3'b000;
        @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b0) begin n_fail++; $display("FAIL single_release_blank: got %b, expected 0", seg_en); end
        repeat (25) @(negedge sys_clk);
        drain("single");
    endtask

    task automatic test_round_robin();
        int n;
        int m;
        do_reset();
        @(negedge sys_clk);
        req = 3'b111;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (seg_en === 1'b1 && n < 200) begin
                n++;
                @(negedge sys_clk);
            end
            n_tests++;
            if (n !== 30) begin n_fail++; $display("FAIL rr_show_len[%0d]: got %0d cycles, expected 30", i, n); end
            m = 0;
            while (seg_en === 1'b0 && m < 200) begin
                m++;
                @(negedge sys_clk);
            end
            n_tests++;
            if (m !== 20) begin n_fail++; $display("FAIL rr_blank_len[%0d]: got %0d cycles, expected 20", i, m); end
        end
        drain("rr");
        req = 3'b000;
        repeat (40) @(negedge sys_clk);
    endtask

    task automatic test_early_exit();
        do_reset();
        @(negedge sys_clk);
        req = 3'b010;
        exp_q.push_back(3'b010);
        @(negedge sys_clk);
        repeat (12) @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b1) begin n_fail++; $display("FAIL early_still_show: got %b, expected 1", seg_en); end
        req = 3'b000;
        @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b0 || gnt !== 3'b000) begin
            n_fail++; $display("FAIL early_blank: got seg_en=%b gnt=%b, expected 0/000", seg_en, gnt);
        end
        repeat (5) @(negedge sys_clk);
        req = 3'b100;
        repeat (3) @(negedge sys_clk);
        req = 3'b000;
        repeat (20) @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b0) begin n_fail++; $display("FAIL early_blank_ignores_req: got %b, expected 0", seg_en); end
        req = 3'b001;
        exp_q.push_back(3'b001);
        @(negedge sys_clk);
        n_tests++;
        if (gnt !== 3'b001) begin n_fail++; $display("FAIL early_idle_regrant: got %b, expected 001", gnt); end
        drain("early");
        req = 3'b000;
        repeat (30) @(negedge sys_clk);
    endtask

    task automatic test_clamp();
        logic [19:0] vin [4];
        logic [19:0] vexp [4];
        vin[0] = 20'd999_998;   vexp[0] = 20'd999_998;
        vin[1] = 20'd999_999;   vexp[1] = 20'd999_999;
        vin[2] = 20'd1_000_000; vexp[2] = 20'd999_999;
        vin[3] = 20'd0;         vexp[3] = 20'd0;
        do_reset();
        @(negedge sys_clk);
        data_in  = {20'hFFFFF, 20'd5, 20'd7};
        point_in = {6'b101011, 6'b000000, 6'b111111};
        sign_in  = 3'b100;
        req      = 3'b100;
        exp_q.push_back(3'b100);
        repeat (2) @(negedge sys_clk);
        n_tests++;
        if (data !== 20'd999_999) begin n_fail++; $display("FAIL clamp_fffff: got %0d, expected 999999", data); end
        n_tests++;
        if (point !== 6'b101011) begin n_fail++; $display("FAIL clamp_point: got %b, expected 101011", point); end
        n_tests++;
        if (sign !== 1'b1) begin n_fail++; $display("FAIL clamp_sign: got %b, expected 1", sign); end
        for (int i = 0; i < 4; i++) begin
            data_in[59:40] = vin[i];
            sign_in        = 3'b011;
            @(negedge sys_clk);
            n_tests++;
            if (data !== vexp[i] || sign !== 1'b0) begin
                n_fail++;
                $display("FAIL clamp_edge[%0d]: got %0d/%b, expected %0d/0", i, data, sign, vexp[i]);
            end
        end
        drain("clamp");
        req = 3'b000;
        repeat (30) @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        @(negedge sys_clk);
        data_in[19:0] = 20'd123456;
        point_in[5:0] = 6'h3f;
        sign_in       = 3'b001;
        req           = 3'b001;
        exp_q.push_back(3'b001);
        repeat (8) @(negedge sys_clk);
        n_tests++;
        if (data !== 20'd123456) begin n_fail++; $display("FAIL rstmid_pre_data: got %0d, expected 123456", data); end
        drain("rstmid_pre");
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 3'b000 || seg_en !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async_ctrl: got gnt=%b seg_en=%b, expected 000/0", gnt, seg_en);
        end
        n_tests++;
        if (data !== 20'd0 || point !== 6'd0 || sign !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async_data: got %0d/%b/%b, expected 0/000000/0", data, point, sign);
        end
        req = 3'b110;
        @(negedge sys_clk);
        n_tests++;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL rstmid_held: got %b, expected 000", gnt); end
        sys_rst_n = 1'b1;
        exp_q.push_back(3'b010);
        @(negedge sys_clk);
        n_tests++;
        if (gnt !== 3'b010) begin n_fail++; $display("FAIL rstmid_first_grant: got %b, expected 010", gnt); end
        drain("rstmid");
        req = 3'b000;
        repeat (30) @(negedge sys_clk);
    endtask

    task automatic test_simultaneous();
        int m;
        do_reset();
        @(negedge sys_clk);
        req = 3'b001;
        exp_q.push_back(3'b001);
        @(negedge sys_clk);
        repeat (28) @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b1) begin n_fail++; $display("FAIL sim_still_show: got %b, expected 1", seg_en); end
        @(negedge sys_clk);
        req = 3'b100;
        exp_q.push_back(3'b100);
        @(negedge sys_clk);
        n_tests++;
        if (seg_en !== 1'b0 || gnt !== 3'b000) begin
            n_fail++; $display("FAIL sim_blank: got seg_en=%b gnt=%b, expected 0/000", seg_en, gnt);
        end
        m = 0;
        while (seg_en === 1'b0 && m < 200) begin
            m++;
            @(negedge sys_clk);
        end
        n_tests++;
        if (m !== 20) begin n_fail++; $display("FAIL sim_blank_len: got %0d cycles, expected 20", m); end
        drain("sim");
        req = 3'b000;
        repeat (30) @(negedge sys_clk);
    endtask

    task automatic test_invariant();
        n_tests++;
        if (inv_bad !== 0) begin
            n_fail++; $display("FAIL gnt_invariant: got %0d bad cycles, expected 0", inv_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_round_robin();
        test_early_exit();
        test_clamp();
        test_reset_mid_show();
        test_simultaneous();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
